// File: rtl/double_exp_pkg.sv
// Shared types and elaboration helpers for the double_exp_seq modular double-exponentiator.
package double_exp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        SQUARE,
        DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int unsigned latency(input int unsigned w, input int unsigned n);
        return (w + 1) + n * w + 1;
    endfunction

    function automatic bit params_ok(input int unsigned w, input int unsigned m);
        return (w >= 1) && (w <= 30) && (m >= 2) && (64'(m) <= ((64'd1 << w) - 1));
    endfunction

endpackage

// File: rtl/double_exp_seq_mod_dbl_add.sv
// mod_dbl_add: combinational (2*r + addend) mod M for r, addend < M; result < M.
module mod_dbl_add #(
    parameter int unsigned W = 8,
    parameter int unsigned M = 221
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] addend,
    output logic [W-1:0] y
);
    localparam logic [W+1:0] MOD = (W+2)'(M);

    logic [W+1:0] t0;
    logic [W+1:0] t1;
    logic [W+1:0] t2;

    // 2r + addend < 3M, so two conditional subtractions always land in [0, M).
    always_comb begin
        t0 = {1'b0, r, 1'b0} + {2'b00, addend};
        t1 = (t0 >= MOD) ? t0 - MOD : t0;
        t2 = (t1 >= MOD) ? t1 - MOD : t1;
        y  = W'(t2);
    end

endmodule

// File: rtl/double_exp_seq.sv
// double_exp_seq: y = (xs+xc)^(2^N) mod M, bit-serial via one shared mod_dbl_add.
// Define DOUBLE_EXP_ABORT_EN to let ld restart a computation already in progress.
module double_exp_seq
    import double_exp_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned M = 221,
    parameter int unsigned N = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] xs,
    input  logic [W-1:0] xc,
    output logic         busy,
    output logic         dn,
    output logic [W-1:0] ys,
    output logic [W-1:0] yc
);
    localparam int unsigned BW = clog2(W + 2);
    localparam int unsigned PW = cnt_width(N + 1);
    localparam logic [BW-1:0] BIT_NORM  = BW'(W);
    localparam logic [BW-1:0] BIT_SQ    = BW'(W - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'((N == 0) ? 0 : N - 1);

    if (!params_ok(W, M)) begin : g_param_check
        $fatal(1, "double_exp_seq: illegal W/M combination");
    end

    state_t        state;
    logic [W:0]    a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  acc;
    logic [W-1:0]  r;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] pass_cnt;
    logic [W-1:0]  r_in;
    logic [W-1:0]  addend;
    logic [W-1:0]  sum;
    logic          start;

`ifdef DOUBLE_EXP_ABORT_EN
    assign start = ld && (state != DONE);
`else
    assign start = ld && (state == IDLE);
`endif

    // acc is the squaring operand b for the whole pass; b_sh only supplies its bits MSB first.
    always_comb begin
        r_in   = r;
        addend = '0;
        if (state == NORM) begin
            r_in   = acc;
            addend = W'(a_sh[W]);
        end else if (b_sh[W-1]) begin
            addend = acc;
        end
    end

    mod_dbl_add #(.W(W), .M(M)) u_dbl_add (
        .r      (r_in),
        .addend (addend),
        .y      (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            dn       <= 1'b0;
            ys       <= '0;
            yc       <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            r        <= '0;
            bit_cnt  <= '0;
            pass_cnt <= '0;
        end else begin
            dn <= 1'b0;
            if (start) begin
                state    <= NORM;
                busy     <= 1'b1;
                a_sh     <= (W+1)'(xs) + (W+1)'(xc);
                acc      <= '0;
                r        <= '0;
                bit_cnt  <= BIT_NORM;
                pass_cnt <= '0;
            end else begin
                case (state)
                    NORM: begin
                        acc  <= sum;
                        a_sh <= a_sh << 1;
                        if (bit_cnt == '0) begin
                            if (N == 0) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= SQUARE;
                                b_sh     <= sum;
                                r        <= '0;
                                bit_cnt  <= BIT_SQ;
                                pass_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    SQUARE: begin
                        b_sh <= b_sh << 1;
                        if (bit_cnt == '0) begin
                            acc     <= sum;
                            b_sh    <= sum;
                            r       <= '0;
                            bit_cnt <= BIT_SQ;
                            if (pass_cnt == PASS_LAST) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                        end else begin
                            r       <= sum;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        ys    <= acc;
                        yc    <= '0;
                        dn    <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
